uart_bus_bridge: RTL and testbench
==================================

// Module: uart_bus_bridge
// PURPOSE
//  UART-to-IO-bus initiator (host debug bridge). Receives command frames on a serial RX line.
//  Issues single 32-bit read/write transactions as master on the IO interconnect. Returns the
//  ack or read data on a serial TX line. Sits beside the CPU as a second IO bus master, used
//  for bring-up and for poking MMIO peripherals (UART, GPIO, timers) from a PC.
// PARAMETERS
//  BAUD_DIV       650   baud divider terminal count (same tick scheme as UART core; 650 = 9600)
//  TIMEOUT_TICKS  2048  baud_pulse ticks allowed between consecutive frame bytes before abort
//  RD_LATENCY     1     cycles from io_bus_m_rd_en to valid io_bus_m_rd_data (1..3)
// PORTS
//  clk                input   1   system clock
//  rst_n              input   1   reset, asynchronous, active-low
//  uart_rx            input   1   serial in from host
//  uart_tx            output  1   serial out to host
//  io_bus_m_rd_en     output  1   1-cycle read strobe
//  io_bus_m_wr_en     output  1   1-cycle write strobe
//  io_bus_m_address   output  32  transaction address
//  io_bus_m_wr_data   output  32  write data
//  io_bus_m_rd_data   input   32  read data from interconnect
//  busy               output  1   high whenever FSM not in IDLE
//  frame_err          output  1   1-cycle pulse: bad opcode or inter-byte timeout
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low. Instantiates existing uart_rx/uart_tx;
//   their rst driven by ~rst_n.
//  Baud: divisor counts 0..BAUD_DIV, wraps to 0; baud_pulse = (divisor == 1); shared by rx and tx.
//  Frame (bytes LSB-first): 'W'(0x57) A0 A1 A2 A3 D0 D1 D2 D3 | 'R'(0x52) A0 A1 A2 A3.
//  Response: write -> single 0x06 (ACK); read -> D0 D1 D2 D3; bad opcode -> single 0x15 (NAK).
//  FSM states: IDLE, ADDR, WDATA, BUS_WR, BUS_RD, RD_WAIT, TX_RESP.
//   IDLE: on rx_done: 0x57/0x52 -> ADDR (latch op), else frame_err pulse, queue NAK -> TX_RESP.
//   ADDR: shift 4 bytes into address[8*i +: 8], i = byte_cnt (2-bit); after A3: W -> WDATA, R -> BUS_RD.
//   WDATA: 4 bytes into wr_data likewise; after D3 -> BUS_WR.
//   BUS_WR: wr_en high exactly 1 cycle, addr/data stable that cycle; queue ACK -> TX_RESP.
//   BUS_RD: rd_en high exactly 1 cycle -> RD_WAIT; capture rd_data RD_LATENCY cycles after rd_en;
//    queue 4 bytes -> TX_RESP.
//   TX_RESP: tx_start held high with tx_data stable until uart_tx_done; then next byte; after last -> IDLE.
//  Timeout: tick counter cleared on every rx_done and on entering ADDR; in ADDR/WDATA, reaching
//   TIMEOUT_TICKS -> frame_err pulse, no bus access, no response, -> IDLE.
//  RX bytes arriving in BUS_WR/BUS_RD/RD_WAIT/TX_RESP are discarded (no buffering, no error).
//  io_bus_m_address/wr_data hold last value between transactions; strobes never both high.
//  Reset values: uart_tx=1 (idle), rd_en=wr_en=0, address=0, wr_data=0, busy=0, frame_err=0,
//   state=IDLE, byte_cnt=0. Reset mid-frame or mid-transmit abandons it; TX line returns to 1
//   immediately (async).
// TESTING
//  1. Host sends 57 10 00 00 80 EF BE AD DE -> one wr_en cycle, addr 0x80000010, data 0xDEADBEEF;
//     TX returns 0x06.
//  2. Host sends 52 04 00 00 80, responder returns 0x12345678 after RD_LATENCY -> one rd_en cycle
//     at 0x80000004; TX 78 56 34 12.
//  3. Host sends 0x41 -> frame_err pulse, no bus strobe, TX 0x15, busy falls after NAK sent.
//  4. Host sends 52 04 then silence > TIMEOUT_TICKS baud ticks -> frame_err, no strobe, no TX, IDLE;
//     next valid frame works.
//  5. Host sends 2nd frame during read response -> extra bytes dropped, response intact,
//     later frame decoded cleanly.
//  6. rst_n low mid-WDATA and mid-TX_RESP -> all outputs at reset values at once; clean frame
//     after release succeeds.

Source files
------------

// File: rtl/uart_bus_bridge.sv
// Host debug bridge: serial command frames in, single 32-bit IO bus reads/writes out,
// ACK/NAK or read data returned on the serial line.
module uart_bus_bridge #(
  parameter int unsigned BAUD_DIV      = 650,
  parameter int unsigned TIMEOUT_TICKS = 2048,
  parameter int unsigned RD_LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        io_bus_m_rd_en,
  output logic        io_bus_m_wr_en,
  output logic [31:0] io_bus_m_address,
  output logic [31:0] io_bus_m_wr_data,
  input  logic [31:0] io_bus_m_rd_data,
  output logic        busy,
  output logic        frame_err
);

  localparam int unsigned DIV_W = $clog2(BAUD_DIV + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_BUS_WR, S_BUS_RD, S_RD_WAIT, S_TX_RESP
  } state_t;

  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic             r_rx_meta, r_rx_sync;
  logic             r_rx_busy, r_rx_done;
  logic [3:0]       r_rx_tcnt, r_rx_bcnt;
  logic [7:0]       r_rx_shift;
  logic             r_tx_busy, r_tx_done;
  logic [3:0]       r_tx_tcnt, r_tx_bcnt;
  logic [9:0]       r_tx_shift;
  logic [TO_W-1:0]  r_to_cnt;
  logic             w_timeout;
  state_t           r_state;
  logic             r_is_wr;
  logic [1:0]       r_byte_cnt, r_resp_last, r_wait_cnt;
  logic [1:0]       w_next_cnt;
  logic [31:0]      r_addr, r_wdata, r_rd_buf;
  logic [7:0]       r_tx_data;
  logic             r_tx_start, r_rd_en, r_wr_en, r_busy, r_frame_err;

  // Shared 16x oversampling tick for both serial directions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_div <= '0;
    else if (r_div == DIV_W'(BAUD_DIV))   r_div <= '0;
    else                                  r_div <= r_div + 1'b1;
  end
  assign w_tick = (r_div == DIV_W'(1));

  // Receiver: start detect, sample mid-bit every 16 ticks, done only on a valid stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_done  <= 1'b0;
      r_rx_tcnt  <= '0;
      r_rx_bcnt  <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_done <= 1'b0;
      if (w_tick) begin
        if (!r_rx_busy) begin
          if (!r_rx_sync) begin
            r_rx_busy <= 1'b1;
            r_rx_tcnt <= '0;
            r_rx_bcnt <= '0;
          end
        end else begin
          r_rx_tcnt <= r_rx_tcnt + 4'd1;
          if (r_rx_tcnt == 4'd7) begin
            r_rx_bcnt <= r_rx_bcnt + 4'd1;
            if (r_rx_bcnt == 4'd0) begin
              if (r_rx_sync) r_rx_busy <= 1'b0;
            end else if (r_rx_bcnt == 4'd9) begin
              r_rx_busy <= 1'b0;
              r_rx_done <= r_rx_sync;
            end else begin
              r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            end
          end
        end
      end
    end
  end

  // Transmitter: the done cycle blocks a reload so a held start is not resent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_tcnt  <= '0;
      r_tx_bcnt  <= '0;
      r_tx_shift <= '1;
    end else begin
      r_tx_done <= 1'b0;
      if (!r_tx_busy) begin
        if (r_tx_start && !r_tx_done) begin
          r_tx_shift <= {1'b1, r_tx_data, 1'b0};
          r_tx_busy  <= 1'b1;
          r_tx_tcnt  <= '0;
          r_tx_bcnt  <= '0;
        end
      end else if (w_tick) begin
        r_tx_tcnt <= r_tx_tcnt + 4'd1;
        if (r_tx_tcnt == 4'd15) begin
          r_tx_shift <= {1'b1, r_tx_shift[9:1]};
          r_tx_bcnt  <= r_tx_bcnt + 4'd1;
          if (r_tx_bcnt == 4'd9) begin
            r_tx_busy <= 1'b0;
            r_tx_done <= 1'b1;
          end
        end
      end
    end
  end

  // Inter-byte timeout; held clear in IDLE so ADDR always starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_to_cnt <= '0;
    else if (r_rx_done || r_state == S_IDLE)  r_to_cnt <= '0;
    else if (w_tick && !w_timeout)            r_to_cnt <= r_to_cnt + 1'b1;
  end
  assign w_timeout  = (r_to_cnt == TO_W'(TIMEOUT_TICKS));
  assign w_next_cnt = r_byte_cnt + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_is_wr     <= 1'b0;
      r_byte_cnt  <= '0;
      r_resp_last <= '0;
      r_wait_cnt  <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd_buf    <= '0;
      r_tx_data   <= '0;
      r_tx_start  <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: if (r_rx_done) begin
          r_busy     <= 1'b1;
          r_byte_cnt <= '0;
          if (r_rx_shift == OP_WR || r_rx_shift == OP_RD) begin
            r_is_wr <= (r_rx_shift == OP_WR);
            r_state <= S_ADDR;
          end else begin
            r_frame_err <= 1'b1;
            r_tx_data   <= NAK;
            r_resp_last <= '0;
            r_tx_start  <= 1'b1;
            r_state     <= S_TX_RESP;
          end
        end
        S_ADDR: if (r_rx_done) begin
          r_addr[{r_byte_cnt, 3'b000} +: 8] <= r_rx_shift;
          r_byte_cnt <= w_next_cnt;
          if (r_byte_cnt == 2'd3) begin
            if (r_is_wr) begin
              r_state <= S_WDATA;
            end else begin
              r_rd_en <= 1'b1;
              r_state <= S_BUS_RD;
            end
          end
        end else if (w_timeout) begin
          r_frame_err <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        S_WDATA: if (r_rx_done) begin
          r_wdata[{r_byte_cnt, 3'b000} +: 8] <= r_rx_shift;
          r_byte_cnt <= w_next_cnt;
          if (r_byte_cnt == 2'd3) begin
            r_wr_en <= 1'b1;
            r_state <= S_BUS_WR;
          end
        end else if (w_timeout) begin
          r_frame_err <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        S_BUS_WR: begin
          r_tx_data   <= ACK;
          r_resp_last <= '0;
          r_byte_cnt  <= '0;
          r_tx_start  <= 1'b1;
          r_state     <= S_TX_RESP;
        end
        S_BUS_RD: begin
          r_wait_cnt <= 2'd1;
          r_state    <= S_RD_WAIT;
        end
        S_RD_WAIT: if (r_wait_cnt == 2'(RD_LATENCY)) begin
          r_rd_buf    <= io_bus_m_rd_data;
          r_tx_data   <= io_bus_m_rd_data[7:0];
          r_resp_last <= 2'd3;
          r_byte_cnt  <= '0;
          r_tx_start  <= 1'b1;
          r_state     <= S_TX_RESP;
        end else begin
          r_wait_cnt <= r_wait_cnt + 2'd1;
        end
        S_TX_RESP: if (r_tx_done) begin
          if (r_byte_cnt == r_resp_last) begin
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_byte_cnt <= w_next_cnt;
            r_tx_data  <= r_rd_buf[{w_next_cnt, 3'b000} +: 8];
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign uart_tx          = r_tx_shift[0];
  assign io_bus_m_rd_en   = r_rd_en;
  assign io_bus_m_wr_en   = r_wr_en;
  assign io_bus_m_address = r_addr;
  assign io_bus_m_wr_data = r_wdata;
  assign busy             = r_busy;
  assign frame_err        = r_frame_err;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: serial host model, 1-cycle-latency bus responder, bus monitor.
module tb_uart_bus_bridge;
  localparam int unsigned BAUD_DIV      = 3;
  localparam int unsigned TIMEOUT_TICKS = 256;
  localparam int unsigned RD_LATENCY    = 1;
  localparam int unsigned BIT_CYC       = 16 * (BAUD_DIV + 1);
  localparam int unsigned RX_WAIT       = 200 * BIT_CYC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        io_bus_m_rd_en, io_bus_m_wr_en;
  logic [31:0] io_bus_m_address, io_bus_m_wr_data, io_bus_m_rd_data;
  logic        busy, frame_err;

  uart_bus_bridge #(
    .BAUD_DIV(BAUD_DIV), .TIMEOUT_TICKS(TIMEOUT_TICKS), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .io_bus_m_rd_en(io_bus_m_rd_en), .io_bus_m_wr_en(io_bus_m_wr_en),
    .io_bus_m_address(io_bus_m_address), .io_bus_m_wr_data(io_bus_m_wr_data),
    .io_bus_m_rd_data(io_bus_m_rd_data), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Responder: data valid only in the cycle after the strobe, garbage otherwise
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_word  = 32'h0;
  always @(posedge clk) rsp_valid <= io_bus_m_rd_en;
  assign io_bus_m_rd_data = rsp_valid ? rsp_word : 32'hBAD0_BAD0;

  int          wr_cnt = 0, rd_cnt = 0, ferr_cnt = 0, tx_low_cnt = 0, both_cnt = 0;
  logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
  always @(negedge clk) begin
    if (io_bus_m_wr_en) begin wr_cnt++; wr_addr = io_bus_m_address; wr_data = io_bus_m_wr_data; end
    if (io_bus_m_rd_en) begin rd_cnt++; rd_addr = io_bus_m_address; end
    if (io_bus_m_wr_en && io_bus_m_rd_en) both_cnt++;
    if (frame_err) ferr_cnt++;
    if (!uart_tx) tx_low_cnt++;
  end

  int n_chk = 0, n_pass = 0;
  int b_wr, b_rd, b_fe, b_tx;
  logic [7:0] fq[$];
  logic [7:0] eq[$];
  bit wait_ok;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic snap();
    b_wr = wr_cnt; b_rd = rd_cnt; b_fe = ferr_cnt; b_tx = tx_low_cnt;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tx"},    32'(uart_tx),          32'h1);
    chk({tag, "_rden"},  32'(io_bus_m_rd_en),   32'h0);
    chk({tag, "_wren"},  32'(io_bus_m_wr_en),   32'h0);
    chk({tag, "_addr"},  io_bus_m_address,      32'h0);
    chk({tag, "_wdata"}, io_bus_m_wr_data,      32'h0);
    chk({tag, "_busy"},  32'(busy),             32'h0);
    chk({tag, "_ferr"},  32'(frame_err),        32'h0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic wait_tx_low(output bit ok);
    int t = 0;
    while (uart_tx !== 1'b0 && t < int'(RX_WAIT)) begin @(negedge clk); t++; end
    ok = (uart_tx === 1'b0);
  endtask

  // Decode one byte off the TX line; returns at mid stop bit
  task automatic rx_expect(input string tag, input logic [7:0] exp);
    logic [7:0] b = '0;
    bit ok;
    wait_tx_low(ok);
    if (ok) begin
      repeat (BIT_CYC / 2) @(negedge clk);
      if (uart_tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT_CYC) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (BIT_CYC) @(negedge clk);
      if (uart_tx !== 1'b1) ok = 1'b0;
    end
    chk(tag, ok ? {24'h0, b} : 32'hFFFF_FFFF, {24'h0, exp});
  endtask

  task automatic xact(input string tag, input logic [7:0] tq[$], input logic [7:0] rq[$]);
    fork
      send_frame(tq);
      foreach (rq[i]) rx_expect($sformatf("%s_rsp%0d", tag, i), rq[i]);
    join
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk_reset("rst0");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 1: write
    snap();
    fq = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    eq = '{8'h06};
    xact("t1", fq, eq);
    repeat (BIT_CYC) @(negedge clk);
    chk("t1_wr_cnt", 32'(wr_cnt - b_wr), 32'd1);
    chk("t1_rd_cnt", 32'(rd_cnt - b_rd), 32'd0);
    chk("t1_addr",   wr_addr, 32'h8000_0010);
    chk("t1_data",   wr_data, 32'hDEAD_BEEF);
    chk("t1_busy",   32'(busy), 32'h0);

    // 2: read
    snap();
    rsp_word = 32'h1234_5678;
    fq = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h80};
    eq = '{8'h78, 8'h56, 8'h34, 8'h12};
    xact("t2", fq, eq);
    chk("t2_rd_cnt", 32'(rd_cnt - b_rd), 32'd1);
    chk("t2_wr_cnt", 32'(wr_cnt - b_wr), 32'd0);
    chk("t2_addr",   rd_addr, 32'h8000_0004);
    chk("t2_wdata_hold", io_bus_m_wr_data, 32'hDEAD_BEEF);

    // 3: bad opcode
    snap();
    fq = '{8'h41};
    eq = '{8'h15};
    xact("t3", fq, eq);
    chk("t3_busy_during", 32'(busy), 32'h1);
    repeat (BIT_CYC) @(negedge clk);
    chk("t3_busy_after", 32'(busy), 32'h0);
    chk("t3_ferr", 32'(ferr_cnt - b_fe), 32'd1);
    chk("t3_strobes", 32'((wr_cnt - b_wr) + (rd_cnt - b_rd)), 32'd0);

    // 4: inter-byte timeout, then a good frame
    snap();
    fq = '{8'h52, 8'h04};
    send_frame(fq);
    repeat (2000) @(negedge clk);
    chk("t4_ferr", 32'(ferr_cnt - b_fe), 32'd1);
    chk("t4_strobes", 32'((wr_cnt - b_wr) + (rd_cnt - b_rd)), 32'd0);
    chk("t4_no_tx", 32'(tx_low_cnt - b_tx), 32'd0);
    chk("t4_busy", 32'(busy), 32'h0);
    snap();
    fq = '{8'h57, 8'h20, 8'h00, 8'h00, 8'h80, 8'h44, 8'h33, 8'h22, 8'h11};
    eq = '{8'h06};
    xact("t4b", fq, eq);
    chk("t4b_wr_cnt", 32'(wr_cnt - b_wr), 32'd1);
    chk("t4b_addr", wr_addr, 32'h8000_0020);
    chk("t4b_data", wr_data, 32'h1122_3344);

    // 5: bytes arriving during the read response are dropped
    snap();
    rsp_word = 32'hCAFE_F00D;
    fq = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h80};
    fork
      begin
        send_frame(fq);
        repeat (200) @(negedge clk);
        send_byte(8'h57);
        send_byte(8'h11);
      end
      begin
        rx_expect("t5_rsp0", 8'h0D);
        rx_expect("t5_rsp1", 8'hF0);
        rx_expect("t5_rsp2", 8'hFE);
        rx_expect("t5_rsp3", 8'hCA);
      end
    join
    repeat (BIT_CYC) @(negedge clk);
    chk("t5_rd_cnt", 32'(rd_cnt - b_rd), 32'd1);
    chk("t5_wr_cnt", 32'(wr_cnt - b_wr), 32'd0);
    chk("t5_ferr", 32'(ferr_cnt - b_fe), 32'd0);
    snap();
    rsp_word = 32'h0BAD_CAFE;
    fq = '{8'h52, 8'h0C, 8'h00, 8'h00, 8'h80};
    eq = '{8'hFE, 8'hCA, 8'hAD, 8'h0B};
    xact("t5b", fq, eq);
    chk("t5b_addr", rd_addr, 32'h8000_000C);
    chk("t5b_rd_cnt", 32'(rd_cnt - b_rd), 32'd1);

    // 6a: reset mid write-data
    snap();
    fq = '{8'h57, 8'h30, 8'h00, 8'h00, 8'h80, 8'h01, 8'h02};
    send_frame(fq);
    chk("t6a_busy_pre", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset("t6a_rst");
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6a_no_wr", 32'(wr_cnt - b_wr), 32'd0);
    fq = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h80, 8'h78, 8'h56, 8'h34, 8'h12};
    eq = '{8'h06};
    xact("t6a_clean", fq, eq);
    chk("t6a_addr", wr_addr, 32'h8000_0040);
    chk("t6a_data", wr_data, 32'h1234_5678);

    // 6b: reset while response byte 0x21 is on the line (mid data bit 2, a zero)
    rsp_word = 32'h8765_4321;
    fq = '{8'h52, 8'h50, 8'h00, 8'h00, 8'h80};
    fork
      send_frame(fq);
      begin
        wait_tx_low(wait_ok);
        repeat (3 * BIT_CYC + BIT_CYC / 2) @(negedge clk);
      end
    join
    chk("t6b_tx_started", 32'(wait_ok), 32'h1);
    chk("t6b_tx_mid", 32'(uart_tx), 32'h0);
    rst_n = 1'b0;
    #1;
    chk_reset("t6b_rst");
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    snap();
    repeat (1000) @(negedge clk);
    chk("t6b_tx_quiet", 32'(tx_low_cnt - b_tx), 32'd0);
    rsp_word = 32'h0F1E_2D3C;
    fq = '{8'h52, 8'h60, 8'h00, 8'h00, 8'h80};
    eq = '{8'h3C, 8'h2D, 8'h1E, 8'h0F};
    xact("t6b_clean", fq, eq);
    chk("t6b_addr", rd_addr, 32'h8000_0060);

    chk("strobe_overlap", 32'(both_cnt), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
